// File: rtl/disc_writer_pkg.sv
// Shared constants, state encoding and byte decode for the flux write path.
package disc_writer_pkg;

    localparam logic [7:0] DW_END     = 8'hFF;
    localparam logic [7:0] DW_OVF     = 8'h00;
    localparam int         DW_CMD_BIT = 7;
    localparam logic [6:0] DW_TMR_MAX = 7'd127;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COUNT   = 3'd2,
        ST_WAITIDX = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        BK_TIMING  = 2'd0,
        BK_OVF     = 2'd1,
        BK_WAITIDX = 2'd2,
        BK_END     = 2'd3
    } byte_kind_e;

    // Timing bytes carry an interval in bits 6:0; command bytes have bit 7 set.
    function automatic byte_kind_e classify(input logic [7:0] b);
        if (b == DW_END)     return BK_END;
        if (b[DW_CMD_BIT])   return BK_WAITIDX;
        if (b == DW_OVF)     return BK_OVF;
        return BK_TIMING;
    endfunction

endpackage

// File: rtl/disc_writer_if.sv
// RAM fetch bus between the writer (master) and acquisition RAM (slave).
interface disc_writer_if;
    logic       READ;
    logic [7:0] DATA;

    modport master (output READ, input DATA);
    modport slave  (input READ, output DATA);
endinterface

// File: rtl/disc_writer_wrdata_pulse_gen.sv
// Retriggerable stretcher: output high PULSE_WIDTH cycles after each trigger.
module disc_writer_wrdata_pulse_gen #(
    parameter int PULSE_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic trig_i,
    input  logic clr_i,
    output logic pulse_o
);

    logic [3:0] cnt_q, cnt_d;

    // A retrigger reloads the full width so back-to-back pulses never shorten.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (trig_i)
            cnt_d = 4'(PULSE_WIDTH);
        else if (cnt_q != '0)
            cnt_d = cnt_q - 4'd1;
    end

    // Width counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign pulse_o = (cnt_q != '0);

endmodule

// File: rtl/disc_writer.sv
// Replays {flag, interval} bytes from RAM as flux pulses on the write data line.
module disc_writer
    import disc_writer_pkg::*;
#(
    parameter int PULSE_WIDTH = 4
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          CLKEN,
    input  logic          RUN,
    input  logic          FD_INDEX_IN,
    disc_writer_if.master ram,
    output logic          FD_WRDATA,
    output logic          FD_WRGATE,
    output logic          BUSY,
    output logic          UNDERRUN
);

    state_e     state_q, state_d;
    logic [7:0] nxt_q, nxt_d;
    logic       nxt_vld_q, nxt_vld_d;
    logic       pend_q, pend_d;
    logic       end_q, end_d;
    logic [6:0] cnt_q, cnt_d;
    logic       nopulse_q, nopulse_d;
    logic       underrun_q, underrun_d;
    logic       run_q;
    logic       idx_s1_q, idx_s2_q, idx_prev_q;

    byte_kind_e kind;
    logic       active, consume, fire, read, idx_edge;

    // Next-state, prefetch slot and counter control.
    always_comb begin
        state_d    = state_q;
        nxt_d      = nxt_q;
        nxt_vld_d  = nxt_vld_q;
        pend_d     = 1'b0;
        end_d      = end_q;
        cnt_d      = cnt_q;
        nopulse_d  = nopulse_q;
        underrun_d = underrun_q;
        consume    = 1'b0;
        fire       = 1'b0;
        kind       = classify(nxt_q);
        active     = (state_q != ST_IDLE) && (state_q != ST_DONE);
        idx_edge   = idx_s2_q & ~idx_prev_q;

        // The byte requested last cycle is on DATA now.
        if (pend_q) begin
            nxt_d     = ram.DATA;
            nxt_vld_d = 1'b1;
            if (ram.DATA == DW_END)
                end_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                nxt_vld_d = 1'b0;
                end_d     = 1'b0;
                if (RUN && !run_q) begin
                    state_d    = ST_LOAD;
                    underrun_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (nxt_vld_q)
                    consume = 1'b1;
            end
            ST_COUNT: begin
                if (CLKEN) begin
                    if (cnt_q == 7'd1) begin
                        fire = ~nopulse_q;
                        if (nxt_vld_q) begin
                            consume = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                            state_d    = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - 7'd1;
                    end
                end
            end
            ST_WAITIDX: begin
                if (idx_edge)
                    state_d = ST_LOAD;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase

        // Consuming the slot dispatches the next byte in the same cycle.
        if (consume) begin
            nxt_vld_d = 1'b0;
            cnt_d     = (kind == BK_OVF) ? DW_TMR_MAX : nxt_q[6:0];
            nopulse_d = (kind == BK_OVF);
            case (kind)
                BK_TIMING, BK_OVF: state_d = ST_COUNT;
                BK_WAITIDX:        state_d = ST_WAITIDX;
                default:           state_d = ST_DONE;
            endcase
        end

        // Refill as soon as the slot frees, including the consuming cycle.
        read   = RUN && active && (!nxt_vld_q || consume) && !pend_q && !end_q;
        pend_d = read;

        // Abort: drop everything except the sticky underrun flag.
        if (!RUN) begin
            state_d   = ST_IDLE;
            nxt_vld_d = 1'b0;
            pend_d    = 1'b0;
            end_d     = 1'b0;
            fire      = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            nxt_q      <= '0;
            nxt_vld_q  <= 1'b0;
            pend_q     <= 1'b0;
            end_q      <= 1'b0;
            cnt_q      <= '0;
            nopulse_q  <= 1'b0;
            underrun_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            nxt_q      <= nxt_d;
            nxt_vld_q  <= nxt_vld_d;
            pend_q     <= pend_d;
            end_q      <= end_d;
            cnt_q      <= cnt_d;
            nopulse_q  <= nopulse_d;
            underrun_q <= underrun_d;
            run_q      <= RUN;
        end
    end

    // Two-flop index synchroniser plus one delayed copy for edge detect.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            idx_s1_q   <= 1'b0;
            idx_s2_q   <= 1'b0;
            idx_prev_q <= 1'b0;
        end else begin
            idx_s1_q   <= FD_INDEX_IN;
            idx_s2_q   <= idx_s1_q;
            idx_prev_q <= idx_s2_q;
        end
    end

    disc_writer_wrdata_pulse_gen #(
        .PULSE_WIDTH (PULSE_WIDTH)
    ) u_pulse (
        .clk     (CLOCK),
        .rst     (RESET),
        .trig_i  (fire),
        .clr_i   (~RUN),
        .pulse_o (FD_WRDATA)
    );

    assign ram.READ  = read;
    assign FD_WRGATE = (state_q == ST_LOAD) || (state_q == ST_COUNT);
    assign BUSY      = active;
    assign UNDERRUN  = underrun_q;

endmodule

// File: tb/tb_disc_writer.sv
// Bench for disc_writer: RAM model, tick-counting reference model, directed and random sessions.
module tb_disc_writer;

    localparam int PW        = 4;
    localparam int MAXC      = 1 << 17;
    localparam int BUDGET    = 4000;
    // First interval starts START_LAT edges after the gate opens:
    // one READ cycle, one latch cycle, one LOAD hand-over cycle.
    localparam int START_LAT = 3;

    logic CLOCK, RESET, CLKEN, RUN, FD_INDEX_IN;
    logic FD_WRDATA, FD_WRGATE, BUSY, UNDERRUN;

    disc_writer_if bus();

    disc_writer #(.PULSE_WIDTH(PW)) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .CLKEN       (CLKEN),
        .RUN         (RUN),
        .FD_INDEX_IN (FD_INDEX_IN),
        .ram         (bus),
        .FD_WRDATA   (FD_WRDATA),
        .FD_WRGATE   (FD_WRGATE),
        .BUSY        (BUSY),
        .UNDERRUN    (UNDERRUN)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   ck [MAXC];
    logic [7:0] mem [16];
    logic [3:0] ram_addr;
    logic ram_clr;
    logic [7:0] seq_q[$];
    int   exp_pulse[$];
    int   exp_gate[$];
    int   exp_done, exp_reads, idx_at, idx_force;

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc <= cyc + 1;

    // RAM: data appears the cycle after READ, address advances per READ.
    always @(posedge CLOCK) begin
        if (ram_clr)
            ram_addr <= '0;
        else if (bus.READ) begin
            bus.DATA <= mem[ram_addr];
            ram_addr <= ram_addr + 4'd1;
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int nth_tick(input int from, input int n);
        int t = from;
        int c = 0;
        while (c < n && t < MAXC - 1) begin
            t++;
            if (ck[t]) c++;
        end
        return t;
    endfunction

    // Expected pulse edges, gate openings and completion from the byte list and tick record.
    task automatic build_model(input int r);
        int t, n;
        logic [7:0] b;
        exp_pulse.delete();
        exp_gate.delete();
        exp_reads = 0;
        exp_done  = -1;
        exp_gate.push_back(r + 1);
        t = r + 1 + START_LAT;
        foreach (seq_q[i]) begin
            b = seq_q[i];
            exp_reads++;
            if (b == 8'hFF) begin
                exp_done = t;
                break;
            end else if (b[7]) begin
                idx_at = (idx_force > 0) ? r + idx_force : t + int'($urandom_range(5, 40));
                // index seen after 2 sync flops + edge detect, then one LOAD edge
                exp_gate.push_back(idx_at + 3);
                t = idx_at + 4;
            end else begin
                n = (b == 8'h00) ? 127 : int'(b);
                t = nth_tick(t, n);
                if (b != 8'h00) exp_pulse.push_back(t);
            end
        end
    endtask

    task automatic gen_random_seq();
        int nb   = $urandom_range(1, 4);
        int widx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
        seq_q.delete();
        for (int i = 0; i < nb; i++) begin
            if (i == widx) seq_q.push_back(8'h80 | 8'($urandom_range(0, 126)));
            if ($urandom_range(0, 3) == 0) seq_q.push_back(8'h00);
            seq_q.push_back(8'($urandom_range(5, 60)));
        end
        seq_q.push_back(8'hFF);
    endtask

    task automatic start_run(output int r);
        RUN = 1'b0;
        repeat (3) @(negedge CLOCK);
        foreach (seq_q[i]) mem[i] = seq_q[i];
        ram_clr = 1'b1;
        @(negedge CLOCK);
        ram_clr = 1'b0;
        r = cyc;
    endtask

    task automatic run_session(input int mode, input bit exp_ur);
        int r, reads, done_at, gate_at_done, wcur, tail;
        int rises[$];
        int widths[$];
        int grises[$];
        bit prev_wr, prev_gate, started, done;
        reads = 0; done_at = -1; gate_at_done = -1; wcur = 0; tail = 0;
        prev_wr = 0; prev_gate = 0; started = 0; done = 0;
        start_run(r);
        for (int i = r + 1; i <= r + BUDGET + 1; i++) begin
            case (mode)
                0:       ck[i] = 1'b1;
                1:       ck[i] = (i % 4 == 0);
                2:       ck[i] = 1'($urandom_range(0, 1));
                default: ck[i] = ($urandom_range(0, 2) == 0);
            endcase
        end
        idx_at = -1;
        if (!exp_ur) build_model(r);
        CLKEN = ck[r + 1];
        RUN   = 1'b1;
        for (int k = 0; k < BUDGET; k++) begin
            @(negedge CLOCK);
            if (FD_WRDATA && !prev_wr) begin rises.push_back(cyc); wcur = 0; end
            if (FD_WRDATA) wcur++;
            if (!FD_WRDATA && prev_wr) widths.push_back(wcur);
            if (FD_WRGATE && !prev_gate) grises.push_back(cyc);
            prev_wr   = FD_WRDATA;
            prev_gate = FD_WRGATE;
            if (bus.READ) reads++;
            if (BUSY) started = 1;
            if (started && !BUSY && !done) begin
                done = 1; done_at = cyc; gate_at_done = FD_WRGATE; tail = 8;
            end
            if (done) begin
                if (tail == 0) break;
                tail--;
            end
            CLKEN = ck[cyc + 1];
            if (cyc == idx_at) FD_INDEX_IN = 1'b1;
            else if (cyc == idx_at + 6) FD_INDEX_IN = 1'b0;
        end
        FD_INDEX_IN = 1'b0;
        chk("session_done", int'(done), 1);
        if (exp_ur) begin
            chk("ur_flag", int'(UNDERRUN), 1);
            chk("ur_gate", int'(FD_WRGATE), 0);
            chk("ur_busy", int'(BUSY), 0);
        end else begin
            chk("done_at", done_at - r, exp_done - r);
            chk("gate_at_done", gate_at_done, 0);
            chk("reads", reads, exp_reads);
            chk("underrun_clear", int'(UNDERRUN), 0);
            chk("n_pulses", rises.size(), exp_pulse.size());
            for (int i = 0; i < rises.size() && i < exp_pulse.size(); i++)
                chk("pulse_at", rises[i] - r, exp_pulse[i] - r);
            chk("n_widths", widths.size(), exp_pulse.size());
            foreach (widths[i]) chk("pulse_width", widths[i], PW);
            chk("n_gate_open", grises.size(), exp_gate.size());
            for (int i = 0; i < grises.size() && i < exp_gate.size(); i++)
                chk("gate_open_at", grises[i] - r, exp_gate[i] - r);
        end
    endtask

    task automatic wait_pulse(input string tag, input int r, input int exp_rel);
        bit seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge CLOCK);
            if (FD_WRDATA) seen = 1;
        end
        chk(tag, seen ? cyc - r : -1, exp_rel);
    endtask

    task automatic chk_all_low(input string tag);
        chk({tag, "_wrdata"}, int'(FD_WRDATA), 0);
        chk({tag, "_wrgate"}, int'(FD_WRGATE), 0);
        chk({tag, "_busy"},   int'(BUSY), 0);
        chk({tag, "_read"},   int'(bus.READ), 0);
        chk({tag, "_underrun"}, int'(UNDERRUN), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        RESET = 1'b1; RUN = 1'b0; CLKEN = 1'b0; FD_INDEX_IN = 1'b0; ram_clr = 1'b1;
        idx_force = 0;
        repeat (3) @(negedge CLOCK);
        chk_all_low("reset");
        RESET = 1'b0; ram_clr = 1'b0;
        @(negedge CLOCK);
        chk_all_low("post_reset");

        // Two intervals at full tick rate.
        seq_q = '{8'h05, 8'h0A, 8'hFF};
        run_session(0, 1'b0);

        // Overflow byte carries 127 ticks into the next interval.
        seq_q = '{8'h00, 8'h03, 8'hFF};
        run_session(0, 1'b0);

        // Wait for index, then one interval.
        seq_q = '{8'h85, 8'h04, 8'hFF};
        idx_force = 200;
        run_session(0, 1'b0);
        idx_force = 0;

        // Sparse tick enable.
        seq_q = '{8'h02, 8'h02, 8'hFF};
        run_session(1, 1'b0);

        // Interval of 1 right after another leaves the slot empty at expiry.
        seq_q = '{8'h01, 8'h01, 8'hFF};
        run_session(0, 1'b1);
        RUN = 1'b0;
        repeat (2) @(negedge CLOCK);
        chk("ur_retained", int'(UNDERRUN), 1);
        seq_q = '{8'h05, 8'hFF};
        run_session(0, 1'b0);

        // Abort during the first pulse while the next byte is in flight.
        seq_q = '{8'h0A, 8'h30, 8'hFF};
        start_run(r);
        CLKEN = 1'b1;
        RUN   = 1'b1;
        wait_pulse("abort_pulse_at", r, 14);
        RUN = 1'b0;
        @(negedge CLOCK);
        chk("abort_wrdata", int'(FD_WRDATA), 0);
        chk("abort_wrgate", int'(FD_WRGATE), 0);
        chk("abort_busy",   int'(BUSY), 0);
        seq_q = '{8'h07, 8'hFF};
        run_session(0, 1'b0);

        // Asynchronous reset while counting with a pulse high.
        seq_q = '{8'h05, 8'h40, 8'hFF};
        start_run(r);
        CLKEN = 1'b1;
        RUN   = 1'b1;
        wait_pulse("rst_pulse_at", r, 9);
        #2 RESET = 1'b1;
        #1 chk_all_low("async_rst");
        @(negedge CLOCK);
        RESET = 1'b0;
        RUN   = 1'b0;

        for (int s = 0; s < 12; s++) begin
            gen_random_seq();
            run_session(s % 4, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
